// File: rtl/comp_seq_32_pkg.sv
// rtl/comp_seq_32_pkg.sv - shared FSM encoding and slice constants for comp_seq_32
//
// Purpose: state encoding, slice geometry and a slice-select helper used by
//          the sequential 32-bit comparator.
// Contents:
//   state_e     - IDLE / RUN / DONE controller states
//   NUM_SLICES  - number of 8-bit slices in a 32-bit operand (4)
//   SLICE_W     - slice width in bits (8)
//   CNT_W       - width of the slice counter
//   LAST_SLICE  - counter value of the most significant slice
//   slice_of()  - returns one byte of a 32-bit word by slice index
package comp_seq_32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned NUM_SLICES = 4;
  localparam int unsigned SLICE_W    = 8;
  localparam int unsigned CNT_W      = 2;

  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

  function automatic logic [SLICE_W-1:0] slice_of(input logic [31:0]      word,
                                                  input logic [CNT_W-1:0] idx);
    logic [SLICE_W-1:0] res;
    case (idx)
      2'd0:    res = word[7:0];
      2'd1:    res = word[15:8];
      2'd2:    res = word[23:16];
      default: res = word[31:24];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/comp_seq_32_byte_cmp.sv
// rtl/comp_seq_32_byte_cmp.sv - combinational unsigned 8-bit slice comparator
//
// Purpose: compares one byte pair; shared across all slices by the top level.
// Ports:
//   a, b - 8-bit slice operands (unsigned)
//   eq   - a == b
//   gt   - a >  b
module byte_cmp
  import comp_seq_32_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic               eq,
  output logic               gt
);

  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/comp_seq_32.sv
// rtl/comp_seq_32.sv - sequential 32-bit signed/unsigned comparator, one byte per cycle
//
// Purpose: captures A, B and is_signed on an accepted start, walks the four
//          byte slices LSB-first through a single byte_cmp, then presents
//          EQ/GT/LT with a one-cycle done pulse.
// Ports:
//   clock      - rising-edge clock
//   reset      - asynchronous active-high reset
//   start      - request, sampled only while idle
//   A, B       - 32-bit operands, captured on the accepted start edge
//   is_signed  - 1 = two's-complement compare, captured with the operands
//   busy       - high in RUN and DONE
//   done       - one-cycle pulse while in DONE
//   EQ, GT, LT - comparison result, held until the next DONE entry
module comp_seq_32
  import comp_seq_32_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        is_signed,
  output logic        busy,
  output logic        done,
  output logic        EQ,
  output logic        GT,
  output logic        LT
);

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [31:0]        a_q,      a_d;
  logic [31:0]        b_q,      b_d;
  logic               sgn_q,    sgn_d;
  logic               eq_acc_q, eq_acc_d;
  logic               gt_acc_q, gt_acc_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic               eq_q,     eq_d;
  logic               gt_q,     gt_d;
  logic               lt_q,     lt_d;

  logic [SLICE_W-1:0] a_byte;
  logic [SLICE_W-1:0] b_byte;
  logic               byte_eq;
  logic               byte_gt;

  // Flipping the sign bit of the top byte maps two's complement onto
  // offset-binary, so the unsigned byte compare orders signed values correctly.
  always_comb begin
    a_byte = slice_of(a_q, cnt_q);
    b_byte = slice_of(b_q, cnt_q);
    if (sgn_q && (cnt_q == LAST_SLICE)) begin
      a_byte[SLICE_W-1] = ~a_byte[SLICE_W-1];
      b_byte[SLICE_W-1] = ~b_byte[SLICE_W-1];
    end
  end

  byte_cmp u_byte_cmp (
    .a  (a_byte),
    .b  (b_byte),
    .eq (byte_eq),
    .gt (byte_gt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    eq_acc_d = eq_acc_q;
    gt_acc_d = gt_acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    eq_d     = eq_q;
    gt_d     = gt_q;
    lt_d     = lt_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          a_d      = A;
          b_d      = B;
          sgn_d    = is_signed;
          cnt_d    = '0;
          eq_acc_d = 1'b1;
          gt_acc_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        // A later (more significant) differing byte overrides any earlier verdict.
        eq_acc_d = eq_acc_q & byte_eq;
        gt_acc_d = byte_eq ? gt_acc_q : byte_gt;
        if (cnt_q == LAST_SLICE) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          eq_d    = eq_acc_d;
          gt_d    = gt_acc_d & ~eq_acc_d;
          lt_d    = ~eq_acc_d & ~gt_acc_d;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      eq_acc_q <= 1'b0;
      gt_acc_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      eq_acc_q <= eq_acc_d;
      gt_acc_q <= gt_acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
      lt_q     <= lt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign EQ   = eq_q;
  assign GT   = gt_q;
  assign LT   = lt_q;

endmodule

// File: tb/tb_comp_seq_32.sv
// tb/tb_comp_seq_32.sv - self-checking bench for comp_seq_32
module tb_comp_seq_32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        is_signed = 1'b0;
  logic        busy, done, EQ, GT, LT;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  comp_seq_32 dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .A         (A),
    .B         (B),
    .is_signed (is_signed),
    .busy      (busy),
    .done      (done),
    .EQ        (EQ),
    .GT        (GT),
    .LT        (LT)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Behavioural model: cycles since acceptance, result from whole-word compare.
  int          m_phase = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic        m_s = 1'b0;
  logic        m_eq = 1'b0, m_gt = 1'b0, m_lt = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase <= 0;
      m_eq    <= 1'b0;
      m_gt    <= 1'b0;
      m_lt    <= 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_a     <= A;
        m_b     <= B;
        m_s     <= is_signed;
        m_phase <= 1;
      end
    end else if (m_phase == 4) begin
      m_phase <= 5;
      m_eq    <= (m_a == m_b);
      m_gt    <= m_s ? ($signed(m_a) > $signed(m_b)) : (m_a > m_b);
      m_lt    <= m_s ? ($signed(m_a) < $signed(m_b)) : (m_a < m_b);
    end else if (m_phase == 5) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("model_busy", {31'd0, busy}, {31'd0, (m_phase != 0)});
      check("model_done", {31'd0, done}, {31'd0, (m_phase == 5)});
      check("model_res",  {29'd0, EQ, GT, LT}, {29'd0, m_eq, m_gt, m_lt});
    end
  end

  // Drives one compare starting at the current negedge; returns in the IDLE cycle after done.
  task automatic run_cmp(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [2:0] exp);
    int cyc;
    A = a; B = b; is_signed = s; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 12) begin
      check({name, "_busy"}, {31'd0, busy}, 32'd1);
      @(negedge clock);
      cyc++;
    end
    check({name, "_latency"}, cyc, 5);
    check({name, "_res"}, {29'd0, EQ, GT, LT}, {29'd0, exp});
    @(negedge clock);
    check({name, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [2:0]  exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"eq_u",      32'h12345678, 32'h12345678, 1'b0, 3'b100});
    vecs.push_back('{"hi_over",   32'h00000100, 32'h000000FF, 1'b0, 3'b010});
    vecs.push_back('{"msb_u",     32'h80000000, 32'h00000001, 1'b0, 3'b010});
    vecs.push_back('{"msb_s",     32'h80000000, 32'h00000001, 1'b1, 3'b001});
    vecs.push_back('{"neg_s",     32'hFFFFFF00, 32'h000000FF, 1'b1, 3'b001});
    vecs.push_back('{"neg_u",     32'hFFFFFF00, 32'h000000FF, 1'b0, 3'b010});
    vecs.push_back('{"max_min_s", 32'h7FFFFFFF, 32'h80000000, 1'b1, 3'b010});
    vecs.push_back('{"zero_m1_s", 32'h00000000, 32'hFFFFFFFF, 1'b1, 3'b010});
    vecs.push_back('{"eq_s",      32'h80000000, 32'h80000000, 1'b1, 3'b100});

    #1;
    check("reset_outs", {27'd0, busy, done, EQ, GT, LT}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clock);

    foreach (vecs[i]) run_cmp(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp);

    // Start re-pulsed with new operands while busy, and during DONE: all ignored.
    A = 32'd5; B = 32'd9; is_signed = 1'b0; start = 1'b1;
    @(negedge clock);                                  // cycle 1
    start = 1'b0;
    @(negedge clock);                                  // cycle 2
    start = 1'b1; A = 32'd9; B = 32'd5;
    @(negedge clock);                                  // cycle 3
    A = 32'd1; B = 32'd0;
    @(negedge clock);                                  // cycle 4
    A = 32'hFFFFFFFF; B = 32'd0;
    @(negedge clock);                                  // cycle 5 (DONE)
    check("busy_ign_done", {31'd0, done}, 32'd1);
    check("busy_ign_res", {29'd0, EQ, GT, LT}, 32'd1);
    A = 32'd9; B = 32'd5;
    @(negedge clock);                                  // cycle 6: start in DONE was not taken
    start = 1'b0;
    check("done_start_ign", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 7; k++) begin
      check("no_second_done", {31'd0, done}, 32'd0);
      @(negedge clock);
    end
    run_cmp("after_ign", 32'd9, 32'd5, 1'b0, 3'b010);

    // Asynchronous reset in the middle of the third RUN cycle.
    A = 32'h00000001; B = 32'h00000002; is_signed = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check("async_reset_outs", {27'd0, busy, done, EQ, GT, LT}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("abort_no_done", {31'd0, done}, 32'd0);
      @(negedge clock);
    end
    run_cmp("post_reset", 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 3'b010);

    repeat (2) @(negedge clock);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
